pll_phase_ctrl: RTL and testbench

- Single-clock controller placed beside an ECP5 EHXPLLL, running on the PLL reference clock `clkin`.
- Synchronises and qualifies the PLL LOCK signal.
- Releases per-output reset lines in a staggered order once lock is stable.
- Drives the dynamic phase port (PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG) from a valid/ready request interface, so the phase of any of up to 4 outputs can be trimmed at run time.
- Successor to the fixed-phase PLL wrappers: generalised in output count, with lock supervision and dynamic phase behaviour the fixed wrappers lack.

---
 rtl/pll_phase_ctrl_if.sv | 32 +++
 rtl/pll_phase_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_phase_ctrl_if.sv
// Request interface for pll_phase_ctrl.
//
// Carries the phase-step request handshake plus the completion and rejection
// pulses.
//   req_valid  requester -> controller  request valid
//   req_ready  controller -> requester  controller idle, request accepted this cycle if valid
//   req_sel    requester -> controller  PLL output select (0=CLKOP .. 3=CLKOS3)
//   req_dir    requester -> controller  step direction (1 = lag)
//   req_steps  requester -> controller  number of phase steps
//   req_load   requester -> controller  issue PHASELOADREG after the steps
//   step_done  controller -> requester  one-cycle pulse, request completed
//   req_err    controller -> requester  one-cycle pulse, request rejected
interface pll_phase_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       req_load;
  logic       step_done;
  logic       req_err;

  modport master (
    output req_valid, req_sel, req_dir, req_steps, req_load,
    input  req_ready, step_done, req_err
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_steps, req_load,
    output req_ready, step_done, req_err
  );
endinterface

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL lock supervisor and dynamic phase controller.
//
// Runs on the PLL reference clock. Qualifies the PLL LOCK output, releases the
// per-output resets in a staggered order once lock is stable, and turns
// phase-step requests into PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG activity.
//
// Ports:
//   clkin         PLL reference clock
//   resetn        asynchronous active-low reset
//   pll_lock      raw EHXPLLL LOCK (asynchronous)
//   req           request interface (slave side)
//   phasesel      to PHASESEL[1:0]
//   phasedir      to PHASEDIR
//   phasestep     to PHASESTEP (idle 1)
//   phaseloadreg  to PHASELOADREG (idle 1)
//   locked_stable lock has been held for LOCK_STABLE_CYC cycles
//   rst_out_n     per-output-domain active-low resets
//   relock_count  saturating count of lock-loss events
module pll_phase_ctrl #(
  parameter int NUM_OUT         = 4,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int RST_STAGGER_CYC = 8,
  parameter int STEP_PULSE_CYC  = 4,
  parameter int STEP_GAP_CYC    = 4
) (
  input  logic               clkin,
  input  logic               resetn,
  input  logic               pll_lock,
  pll_phase_ctrl_if.slave    req,
  output logic [1:0]         phasesel,
  output logic               phasedir,
  output logic               phasestep,
  output logic               phaseloadreg,
  output logic               locked_stable,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic [7:0]         relock_count
);

  // One counter serves both lock qualification and pulse/gap timing.
  localparam int CNT_MAX  = (LOCK_STABLE_CYC > STEP_PULSE_CYC) ?
                            ((LOCK_STABLE_CYC > STEP_GAP_CYC) ? LOCK_STABLE_CYC : STEP_GAP_CYC) :
                            ((STEP_PULSE_CYC > STEP_GAP_CYC) ? STEP_PULSE_CYC : STEP_GAP_CYC);
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int STAG_MAX = (NUM_OUT - 1) * RST_STAGGER_CYC;
  localparam int SW       = (STAG_MAX < 1) ? 1 : $clog2(STAG_MAX + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK, QUALIFY, READY, SETUP, STEP_LO, STEP_HI, LOAD_LO, LOAD_HI
  } state_t;

  state_t             state_q, state_d;
  logic               lock_meta_q, lock_s_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         steps_q, steps_d;
  logic               load_q, load_d;
  logic [1:0]         phasesel_q, phasesel_d;
  logic               phasedir_q, phasedir_d;
  logic               phasestep_q, phasestep_d;
  logic               phaseloadreg_q, phaseloadreg_d;
  logic               locked_stable_q, locked_stable_d;
  logic [SW-1:0]      rel_cnt_q, rel_cnt_d;
  logic [NUM_OUT-1:0] rst_out_n_q, rst_out_n_d;
  logic               step_done_q, step_done_d;
  logic               req_err_q, req_err_d;
  logic [7:0]         relock_count_q, relock_count_d;
  logic               lock_s;
  logic               lock_held;

  assign lock_s = lock_s_q;
  // Lock is considered held in READY and every request-handling state.
  assign lock_held = (state_q != WAIT_LOCK) && (state_q != QUALIFY);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    steps_d         = steps_q;
    load_d          = load_q;
    phasesel_d      = phasesel_q;
    phasedir_d      = phasedir_q;
    locked_stable_d = locked_stable_q;
    step_done_d     = 1'b0;
    req_err_d       = 1'b0;
    relock_count_d  = relock_count_q;

    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = QUALIFY;
      end
      QUALIFY: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_STABLE_CYC - 1)) begin
          state_d         = READY;
          cnt_d           = '0;
          locked_stable_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      READY: begin
        cnt_d = '0;
        if (req.req_valid) begin
          steps_d = req.req_steps;
          load_d  = req.req_load;
          if (int'(req.req_sel) >= NUM_OUT) begin
            req_err_d = 1'b1;
          end else begin
            state_d    = SETUP;
            phasesel_d = req.req_sel;
            phasedir_d = req.req_dir;
          end
        end
      end
      SETUP: begin
        cnt_d = '0;
        if (steps_q != 8'd0) begin
          state_d = STEP_LO;
        end else if (load_q) begin
          state_d = LOAD_LO;
        end else begin
          state_d     = READY;
          step_done_d = 1'b1;
        end
      end
      STEP_LO: begin
        if (cnt_q == CW'(STEP_PULSE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = STEP_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STEP_HI: begin
        if (cnt_q == CW'(STEP_GAP_CYC - 1)) begin
          cnt_d   = '0;
          steps_d = steps_q - 8'd1;
          if (steps_q != 8'd1) begin
            state_d = STEP_LO;
          end else if (load_q) begin
            state_d = LOAD_LO;
          end else begin
            state_d     = READY;
            step_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOAD_LO: begin
        if (cnt_q == CW'(STEP_PULSE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = LOAD_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOAD_HI: begin
        if (cnt_q == CW'(STEP_GAP_CYC - 1)) begin
          cnt_d       = '0;
          state_d     = READY;
          step_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Lock loss overrides whatever the request logic decided: any in-flight
    // request is dropped silently and the phase port returns to idle.
    if (lock_held && !lock_s) begin
      state_d         = WAIT_LOCK;
      cnt_d           = '0;
      steps_d         = 8'd0;
      load_d          = 1'b0;
      phasesel_d      = 2'd0;
      phasedir_d      = 1'b1;
      locked_stable_d = 1'b0;
      step_done_d     = 1'b0;
      req_err_d       = 1'b0;
      relock_count_d  = (relock_count_q == 8'hFF) ? relock_count_q : relock_count_q + 8'd1;
    end

    // Pulses are registered from the next state so they drop and recover on
    // the same edge as the state change, including a forced abort.
    phasestep_d    = (state_d != STEP_LO);
    phaseloadreg_d = (state_d != LOAD_LO);

    // Stagger timer: zero on the READY entry edge, then counts while the lock
    // stays qualified, independent of request handling.
    if (!locked_stable_d || !locked_stable_q) begin
      rel_cnt_d = '0;
    end else if (rel_cnt_q != SW'(STAG_MAX)) begin
      rel_cnt_d = rel_cnt_q + SW'(1);
    end else begin
      rel_cnt_d = rel_cnt_q;
    end
  end

  // Output i is released once the stagger timer reaches i*RST_STAGGER_CYC.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_rel
    if (gi * RST_STAGGER_CYC == 0) begin : g_first
      assign rst_out_n_d[gi] = locked_stable_d;
    end else begin : g_later
      localparam logic [SW-1:0] REL_AT = SW'(gi * RST_STAGGER_CYC);
      assign rst_out_n_d[gi] = locked_stable_d && (rel_cnt_d >= REL_AT);
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lock_meta_q     <= 1'b0;
      lock_s_q        <= 1'b0;
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      steps_q         <= 8'd0;
      load_q          <= 1'b0;
      phasesel_q      <= 2'd0;
      phasedir_q      <= 1'b1;
      phasestep_q     <= 1'b1;
      phaseloadreg_q  <= 1'b1;
      locked_stable_q <= 1'b0;
      rel_cnt_q       <= '0;
      rst_out_n_q     <= '0;
      step_done_q     <= 1'b0;
      req_err_q       <= 1'b0;
      relock_count_q  <= 8'd0;
    end else begin
      lock_meta_q     <= pll_lock;
      lock_s_q        <= lock_meta_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      steps_q         <= steps_d;
      load_q          <= load_d;
      phasesel_q      <= phasesel_d;
      phasedir_q      <= phasedir_d;
      phasestep_q     <= phasestep_d;
      phaseloadreg_q  <= phaseloadreg_d;
      locked_stable_q <= locked_stable_d;
      rel_cnt_q       <= rel_cnt_d;
      rst_out_n_q     <= rst_out_n_d;
      step_done_q     <= step_done_d;
      req_err_q       <= req_err_d;
      relock_count_q  <= relock_count_d;
    end
  end

  assign req.req_ready  = (state_q == READY);
  assign req.step_done  = step_done_q;
  assign req.req_err    = req_err_q;
  assign phasesel       = phasesel_q;
  assign phasedir       = phasedir_q;
  assign phasestep      = phasestep_q;
  assign phaseloadreg   = phaseloadreg_q;
  assign locked_stable  = locked_stable_q;
  assign rst_out_n      = rst_out_n_q;
  assign relock_count   = relock_count_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl with reduced timing parameters.
module tb_pll_phase_ctrl;
  localparam int NUM_OUT  = 3;
  localparam int LOCK_CYC = 20;
  localparam int STAG     = 5;
  localparam int PULSE    = 4;
  localparam int GAP      = 3;
  localparam int ACT      = PULSE + GAP;
  // pll_lock drive -> locked_stable: 2 synchroniser edges, 1 WAIT_LOCK exit, LOCK_CYC qualify cycles
  localparam int LOCK_LAT = 2 + 1 + LOCK_CYC;

  logic               clk = 1'b0;
  logic               resetn;
  logic               pll_lock;
  logic [1:0]         phasesel;
  logic               phasedir;
  logic               phasestep;
  logic               phaseloadreg;
  logic               locked_stable;
  logic [NUM_OUT-1:0] rst_out_n;
  logic [7:0]         relock_count;

  pll_phase_ctrl_if bus ();

  pll_phase_ctrl #(
    .NUM_OUT(NUM_OUT), .LOCK_STABLE_CYC(LOCK_CYC), .RST_STAGGER_CYC(STAG),
    .STEP_PULSE_CYC(PULSE), .STEP_GAP_CYC(GAP)
  ) dut (
    .clkin(clk), .resetn(resetn), .pll_lock(pll_lock), .req(bus),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg), .locked_stable(locked_stable),
    .rst_out_n(rst_out_n), .relock_count(relock_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cur_sel  = 0;
  int cur_dir  = 1;
  int exp_relock = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_phasesel"}, 32'(phasesel), 0);
    chk({tag, "_phasedir"}, 32'(phasedir), 1);
    chk({tag, "_phasestep"}, 32'(phasestep), 1);
    chk({tag, "_phaseloadreg"}, 32'(phaseloadreg), 1);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_locked_stable"}, 32'(locked_stable), 0);
    chk({tag, "_rst_out_n"}, 32'(rst_out_n), 0);
    chk({tag, "_step_done"}, 32'(bus.step_done), 0);
    chk({tag, "_req_err"}, 32'(bus.req_err), 0);
  endtask

  // Reference: cycle t after acceptance; SETUP is t=1, then (steps+load)
  // actions of PULSE low + GAP high cycles, step_done in the cycle after.
  task automatic do_req(input int sel, input int dir, input int steps, input int load);
    int waited = 0;
    int done_t;
    while (bus.req_ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 1);
    if (bus.req_ready !== 1'b1) return;
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'(sel);
    bus.req_dir   = 1'(dir);
    bus.req_steps = 8'(steps);
    bus.req_load  = 1'(load);
    tick();
    bus.req_valid = 1'b0;
    if (sel >= NUM_OUT) begin
      $display("req sel=%0d dir=%0d steps=%0d load=%0d -> rejected", sel, dir, steps, load);
      chk("err_pulse", 32'(bus.req_err), 1);
      chk("err_done", 32'(bus.step_done), 0);
      chk("err_ready", 32'(bus.req_ready), 1);
      chk("err_phasestep", 32'(phasestep), 1);
      chk("err_phaseloadreg", 32'(phaseloadreg), 1);
      chk("err_phasesel", 32'(phasesel), 32'(cur_sel));
      tick();
      chk("err_pulse_end", 32'(bus.req_err), 0);
      chk("err_phasestep2", 32'(phasestep), 1);
      return;
    end
    cur_sel = sel;
    cur_dir = dir;
    done_t  = 2 + (steps + load) * ACT;
    $display("req sel=%0d dir=%0d steps=%0d load=%0d -> step_done expected %0d cycles after accept",
             sel, dir, steps, load, done_t);
    for (int t = 1; t <= done_t; t++) begin
      int exp_step, exp_load, u, a, w;
      if (t > 1) tick();
      exp_step = 1;
      exp_load = 1;
      if (t >= 2) begin
        u = t - 2;
        a = u / ACT;
        w = u % ACT;
        if (a < steps && w < PULSE) exp_step = 0;
        if (load != 0 && a == steps && w < PULSE) exp_load = 0;
      end
      chk("phasestep", 32'(phasestep), 32'(exp_step));
      chk("phaseloadreg", 32'(phaseloadreg), 32'(exp_load));
      chk("phasesel", 32'(phasesel), 32'(sel));
      chk("phasedir", 32'(phasedir), 32'(dir));
      chk("step_done", 32'(bus.step_done), (t == done_t) ? 1 : 0);
      chk("req_ready_busy", 32'(bus.req_ready), (t == done_t) ? 1 : 0);
      chk("req_err_busy", 32'(bus.req_err), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_sel[4]   = '{2, 3, 0, 1};
    int d_dir[4]   = '{0, 1, 1, 0};
    int d_steps[4] = '{3, 2, 0, 0};
    int d_load[4]  = '{1, 0, 0, 1};
    int waited;
    int exp_rst;
    int done_seen;

    resetn        = 1'b0;
    pll_lock      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_sel   = 2'd0;
    bus.req_dir   = 1'b0;
    bus.req_steps = 8'd0;
    bus.req_load  = 1'b0;

    // Reset values
    repeat (3) tick();
    chk_idle_outputs("reset");
    chk("reset_relock", 32'(relock_count), 0);
    resetn = 1'b1;

    // Lock never asserts
    for (int k = 0; k < 4; k++) begin
      repeat (10) tick();
      chk("nolock_rst_out_n", 32'(rst_out_n), 0);
      chk("nolock_req_ready", 32'(bus.req_ready), 0);
      chk("nolock_relock", 32'(relock_count), 0);
    end
    $display("no-lock phase checked");

    // Lock glitch during qualification restarts the count without a relock event
    pll_lock = 1'b1;
    repeat (12) tick();
    chk("glitch_not_yet_locked", 32'(locked_stable), 0);
    pll_lock = 1'b0;
    repeat (3) tick();
    pll_lock = 1'b1;
    for (int j = 0; j <= LOCK_LAT + (NUM_OUT - 1) * STAG + 3; j++) begin
      if (j > 0) tick();
      exp_rst = 0;
      for (int i = 0; i < NUM_OUT; i++)
        if (j >= LOCK_LAT + i * STAG) exp_rst |= (1 << i);
      chk("lock_locked_stable", 32'(locked_stable), (j >= LOCK_LAT) ? 1 : 0);
      chk("lock_req_ready", 32'(bus.req_ready), (j >= LOCK_LAT) ? 1 : 0);
      chk("lock_rst_out_n", 32'(rst_out_n), 32'(exp_rst));
    end
    chk("glitch_relock", 32'(relock_count), 0);
    $display("lock qualified after glitch, stagger checked");

    // Directed requests
    for (int k = 0; k < 4; k++) do_req(d_sel[k], d_dir[k], d_steps[k], d_load[k]);

    // Random requests
    for (int k = 0; k < 12; k++)
      do_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 1)));

    // Lock loss during the 2nd phasestep low pulse
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    chk("loss_ready_wait", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'd1;
    bus.req_dir   = 1'b1;
    bus.req_steps = 8'd3;
    bus.req_load  = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    repeat (1 + ACT) tick();            // now at t = 2 + ACT, first cycle of 2nd low
    chk("loss_second_low", 32'(phasestep), 0);
    pll_lock = 1'b0;
    tick();
    chk("loss_still_low1", 32'(phasestep), 0);
    tick();
    chk("loss_still_low2", 32'(phasestep), 0);
    tick();
    exp_relock = 1;
    chk("loss_phasestep_released", 32'(phasestep), 1);
    chk("loss_rst_out_n", 32'(rst_out_n), 0);
    chk("loss_locked_stable", 32'(locked_stable), 0);
    chk("loss_req_ready", 32'(bus.req_ready), 0);
    chk("loss_phasesel", 32'(phasesel), 0);
    chk("loss_phasedir", 32'(phasedir), 1);
    chk("loss_relock", 32'(relock_count), 32'(exp_relock));
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.step_done === 1'b1 || bus.req_err === 1'b1) done_seen = 1;
    end
    chk("loss_no_completion", 32'(done_seen), 0);
    $display("lock loss mid-step: relock_count=%0d", relock_count);

    // Repeated lock losses saturate the counter
    for (int k = 0; k < 257; k++) begin
      pll_lock = 1'b1;
      waited = 0;
      while (locked_stable !== 1'b1 && waited < 100) begin
        tick();
        waited++;
      end
      chk("relock_lock_wait", 32'(locked_stable), 1);
      pll_lock = 1'b0;
      repeat (3) tick();
      exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
      chk("relock_locked_stable", 32'(locked_stable), 0);
      chk("relock_count", 32'(relock_count), 32'(exp_relock));
    end
    $display("relock loop done: relock_count=%0d", relock_count);

    // Asynchronous reset in the middle of a step pulse
    pll_lock = 1'b1;
    waited = 0;
    while (locked_stable !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    chk("arst_lock_wait", 32'(locked_stable), 1);
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'd2;
    bus.req_dir   = 1'b0;
    bus.req_steps = 8'd2;
    bus.req_load  = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    repeat (2) tick();
    chk("arst_mid_pulse", 32'(phasestep), 0);
    #2;
    resetn = 1'b0;
    #1;
    chk_idle_outputs("arst");
    chk("arst_relock", 32'(relock_count), 0);
    tick();
    resetn = 1'b1;
    repeat (2) tick();
    chk("arst_after_ready", 32'(bus.req_ready), 0);
    chk("arst_after_locked", 32'(locked_stable), 0);
    $display("async reset mid-operation checked");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
